mem_bus_responder: RTL and testbench

MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

---
 rtl/mem_bus_responder_if.sv | 29 ++
 rtl/mem_bus_responder.sv | 121 ++++++++++++
 tb/tb_mem_bus_responder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_responder_if.sv
// Bus bundle between a memory requester and mem_bus_responder.
// The responder sees addr/data_i/data_en/write_en as inputs and
// drives registered read data plus the combinational hit flag.
interface mem_if;
  logic [31:0] addr;
  logic [31:0] data_i;
  logic [3:0]  data_en;
  logic        write_en;
  logic [31:0] data_o;
  logic        hit;

  modport bus (
    input  addr,
    input  data_i,
    input  data_en,
    input  write_en,
    output data_o,
    output hit
  );

  modport drv (
    output addr,
    output data_i,
    output data_en,
    output write_en,
    input  data_o,
    input  hit
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Word-addressed memory behind a single open-row buffer.
// An access to the open row (or to an out-of-range address) is served
// in the cycle it is presented; any other in-range access first spends
// MISS_LATENCY cycles activating its row, during which hit stays low
// and the requester holds its inputs.
module mem_bus_responder #(
  parameter int DEPTH_WORDS  = 1024,
  parameter int ROW_WORDS    = 8,
  parameter int MISS_LATENCY = 3
) (
  input logic clk,
  input logic reset_n,
  mem_if.bus  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);  // word index bits kept
  localparam int RB = $clog2(ROW_WORDS);    // word-in-row bits
  localparam int RW = AW - RB;              // row number bits

  typedef enum logic {
    IDLE,
    ACT
  } state_t;

  state_t          state, state_next;
  logic            row_valid;
  logic [RW-1:0]   open_row;
  logic [RW-1:0]   pend_row;
  logic [3:0]      act_cnt;

  logic [29:0]     word;
  logic [AW-1:0]   idx;
  logic [RW-1:0]   row;
  logic            in_range;
  logic            hit;
  logic            do_write;
  logic [31:0]     merged;
  logic [31:0]     data_q;
  logic [31:0]     mem [DEPTH_WORDS];

  // Byte-address low bits carry no meaning for a word-wide bus.
  logic            unused_addr_bits;
  assign unused_addr_bits = &{1'b0, bus.addr[1:0]};

  assign word     = bus.addr[31:2];
  assign idx      = word[AW-1:0];
  assign row      = idx[AW-1:RB];
  assign in_range = (word < 30'(DEPTH_WORDS));

  // Served this cycle: idle and either nothing to activate or row already open.
  assign hit      = (state == IDLE) && (!in_range || (row_valid && (row == open_row)));
  assign do_write = hit && bus.write_en && in_range;

  assign bus.hit    = hit;
  assign bus.data_o = data_q;

  // Write-first view of the addressed word: enabled bytes replaced by data_i.
  always_comb begin
    // NOTE: the default is assigned before the loop so every path drives merged and no latch is inferred.
    merged = mem[idx];
    for (int b = 0; b < 4; b++) begin
      if (bus.data_en[b]) merged[8*b +: 8] = bus.data_i[8*b +: 8];
    end
  end

  // Next-state logic: misses go to ACT, ACT returns once the count expires.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_range && !hit) state_next = ACT;
      ACT:     if (act_cnt == 4'd1)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Row activation bookkeeping: capture the missing row, count down, open it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_valid <= 1'b0;
      open_row  <= '0;
      pend_row  <= '0;
      act_cnt   <= 4'd0;
    end else if (state == IDLE) begin
      if (state_next == ACT) begin
        pend_row <= row;
        act_cnt  <= 4'(MISS_LATENCY);
      end
    end else begin
      act_cnt <= act_cnt - 4'd1;
      if (act_cnt == 4'd1) begin
        open_row  <= pend_row;
        row_valid <= 1'b1;
      end
    end
  end

  // Read data register: loads only on hit cycles, zero for out-of-range.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= 32'h0;
    end else if (hit) begin
      if (!in_range)         data_q <= 32'h0;
      else if (bus.write_en) data_q <= merged;
      else                   data_q <= mem[idx];
    end
  end

  // Storage array update on accepted writes with at least one byte enabled.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; its contents survive reset_n and power up undefined.
    if (do_write && (bus.data_en != 4'b0000)) mem[idx] <= merged;
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder with default parameters.
// Reference model: a plain word array, the identity of the open row, and
// the rule "a miss is served MISS_LATENCY+1 cycles after it is presented".
module tb_mem_bus_responder;

  localparam int DEPTH = 1024;
  localparam int ROWW  = 8;
  localparam int LAT   = 3;

  logic clk;
  logic reset_n;
  mem_if bif ();

  mem_bus_responder #(
    .DEPTH_WORDS  (DEPTH),
    .ROW_WORDS    (ROWW),
    .MISS_LATENCY (LAT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state.
  logic [31:0] ref_mem [DEPTH];
  bit          ref_valid;
  int          ref_row;
  logic [31:0] ref_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input bit we, input logic [31:0] d, input logic [3:0] en);
    bif.addr     = a;
    bif.write_en = we;
    bif.data_i   = d;
    bif.data_en  = en;
  endtask

  // One complete transaction: wait out any activation, then check the served result.
  task automatic access(input logic [31:0] a, input bit we, input logic [31:0] d, input logic [3:0] en);
    logic [31:0] wi;
    bit          inr;
    int          w;
    int          r;
    bit          miss;
    logic [31:0] nv;
    wi   = {2'b00, a[31:2]};
    inr  = (wi < DEPTH);
    w    = inr ? int'(wi) : 0;
    r    = w / ROWW;
    miss = inr && !(ref_valid && ref_row == r);
    drive(a, we, d, en);
    if (miss) begin
      for (int k = 0; k <= LAT; k++) begin
        @(negedge clk);
        check("hit_low_during_miss", {31'd0, bif.hit}, 32'd0);
        check("data_o_hold", bif.data_o, ref_q);
        @(posedge clk); #1;
      end
      ref_valid = 1'b1;
      ref_row   = r;
    end
    @(negedge clk);
    check("hit_served", {31'd0, bif.hit}, 32'd1);
    if (!inr) begin
      ref_q = 32'h0;
    end else begin
      nv = ref_mem[w];
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (en[b]) nv[8*b +: 8] = d[8*b +: 8];
        ref_mem[w] = nv;
      end
      ref_q = nv;
    end
    @(posedge clk); #1;
    check("data_o", bif.data_o, ref_q);
  endtask

  // Pulse reset for one edge while an in-range address is presented.
  task automatic pulse_reset();
    reset_n = 1'b0;
    @(negedge clk);
    check("reset_data_o", bif.data_o, 32'h0);
    check("reset_hit", {31'd0, bif.hit}, 32'd0);
    @(posedge clk); #1;
    reset_n   = 1'b1;
    ref_valid = 1'b0;
    ref_q     = 32'h0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] wi;
    ref_valid = 1'b0;
    ref_row   = 0;
    ref_q     = 32'h0;
    reset_n   = 1'b0;
    drive(32'h40, 1'b0, 32'h0, 4'h0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("por_data_o", bif.data_o, 32'h0);
    check("por_hit", {31'd0, bif.hit}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Give every word a known zero value.
    for (int w = 0; w < DEPTH; w++) access(32'(w * 4), 1'b1, 32'h0, 4'hF);

    // Memory survives reset; first access after reset is a full-latency miss.
    drive(32'h40, 1'b0, 32'h0, 4'h0);
    pulse_reset();
    access(32'h40, 1'b0, 32'h0, 4'h0);

    // Byte-enabled write-first and read-back.
    access(32'h100, 1'b1, 32'hDEADBEEF, 4'b0101);
    check("partial_write_value", bif.data_o, 32'h00AD00EF);
    access(32'h100, 1'b0, 32'h0, 4'h0);
    check("partial_write_readback", bif.data_o, 32'h00AD00EF);

    // Streaming reads across a row, one per cycle.
    access(32'h44, 1'b1, 32'hA5A5_0001, 4'hF);
    access(32'h58, 1'b1, 32'h1234_5678, 4'b1100);
    for (int i = 0; i < ROWW; i++) access(32'h40 + 32'(i * 4), 1'b0, 32'h0, 4'h0);

    // Write with no byte enables leaves memory unchanged.
    access(32'h104, 1'b1, 32'hFFFF_FFFF, 4'h0);
    access(32'h104, 1'b0, 32'h0, 4'h0);

    // Out-of-range write: immediate hit, zero data, no aliasing into memory.
    access(32'hFFFF_FFF0, 1'b1, 32'h1234_5678, 4'hF);
    check("oor_data_zero", bif.data_o, 32'h0);
    access(32'h0000_0FF0, 1'b0, 32'h0, 4'h0);

    // Reset in the second cycle of an activation abandons it.
    drive(32'h80, 1'b0, 32'h0, 4'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    pulse_reset();
    access(32'h80, 1'b0, 32'h0, 4'h0);

    // Address change mid-activation: row 0 still opens, new address misses again.
    ref_mem[128] = 32'hC0FF_EE00;
    access(32'h200, 1'b1, 32'hC0FF_EE00, 4'hF);
    drive(32'h0, 1'b0, 32'h0, 4'h0);
    for (int k = 0; k <= 8; k++) begin
      if (k == 2) drive(32'h200, 1'b0, 32'h0, 4'h0);
      @(negedge clk);
      check("addr_change_hit", {31'd0, bif.hit}, (k == 8) ? 32'd1 : 32'd0);
      check("addr_change_hold", bif.data_o, ref_q);
      @(posedge clk); #1;
    end
    ref_valid = 1'b1;
    ref_row   = 16;
    ref_q     = ref_mem[128];
    check("addr_change_data", bif.data_o, 32'hC0FF_EE00);
    access(32'h208, 1'b0, 32'h0, 4'h0);

    // Randomized traffic, biased towards a handful of rows so hits and misses mix.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'h0000_1000 | ($urandom & 32'hFFFF_FFFC);
        1, 2:    a = 32'($urandom_range(0, DEPTH - 1) * 4);
        default: a = 32'(($urandom_range(0, 3) * ROWW + $urandom_range(0, ROWW - 1)) * 4);
      endcase
      a[1:0] = 2'($urandom_range(0, 3));
      wi = {2'b00, a[31:2]};
      if (wi >= DEPTH && $urandom_range(0, 1) == 1) a = 32'hFFFF_FFFC;
      access(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
